l2_ahb_in_stg: RTL

- Per-master input stage of the L2 AHB bus matrix. Sits directly upstream of the output-stage arbiter and feeds its per-port request and address/control.
- Captures an address phase the arbiter cannot grant immediately, then replays it once granted.
- Stalls the master via HREADYOUTS while the transfer is pending.
- Tracks the data phase of granted transfers and returns slave HREADY/HRESP to the master.

---
 rtl/l2_ahb_pkg.sv | 37 +++
 rtl/l2_ahb_in_stg_if.sv | 47 ++++
 rtl/l2_ahb_in_hold.sv | 37 +++
 rtl/l2_ahb_in_stg.sv | 108 ++++++++++
 4 files changed

// File: rtl/l2_ahb_pkg.sv
// Shared AHB encodings and input-stage types for the L2 bus matrix.
package l2_ahb_pkg;

  localparam logic [1:0] TRN_IDLE   = 2'b00;
  localparam logic [1:0] TRN_BUSY   = 2'b01;
  localparam logic [1:0] TRN_NONSEQ = 2'b10;
  localparam logic [1:0] TRN_SEQ    = 2'b11;

  localparam logic [2:0] BST_SINGLE = 3'd0;
  localparam logic [2:0] BST_INCR   = 3'd1;
  localparam logic [2:0] BST_WRAP4  = 3'd2;
  localparam logic [2:0] BST_INCR4  = 3'd3;
  localparam logic [2:0] BST_WRAP8  = 3'd4;
  localparam logic [2:0] BST_INCR8  = 3'd5;
  localparam logic [2:0] BST_WRAP16 = 3'd6;
  localparam logic [2:0] BST_INCR16 = 3'd7;

  localparam logic RSP_OKAY  = 1'b0;
  localparam logic RSP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_DATA = 2'd2
  } in_state_e;

  // Address-phase control, excluding the address itself.
  typedef struct packed {
    logic [1:0] trans;
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
    logic       lock;
  } ahb_ctrl_t;

endpackage

// File: rtl/l2_ahb_in_stg_if.sv
// Bus bundle between one AHB master, the input stage and the output-stage arbiter.
interface l2_ahb_in_stg_if #(
  parameter int ADDR_W = 32,
  parameter int WCNT_W = 8
);
  logic              HSELS;
  logic [ADDR_W-1:0] HADDRS;
  logic [1:0]        HTRANSS;
  logic              HWRITES;
  logic [2:0]        HSIZES;
  logic [2:0]        HBURSTS;
  logic [3:0]        HPROTS;
  logic              HMASTLOCKS;
  logic              HREADYS;
  logic              HREADYOUTS;
  logic              HRESPS;
  logic              req_port;
  logic              sel_m;
  logic [ADDR_W-1:0] addr_m;
  logic [1:0]        trans_m;
  logic              write_m;
  logic [2:0]        size_m;
  logic [2:0]        burst_m;
  logic [3:0]        prot_m;
  logic              lock_m;
  logic              grant_m;
  logic              readyout_m;
  logic              resp_m;
  logic              data_active;
  logic [WCNT_W-1:0] pend_cycles;

  // The environment: master plus arbiter/slave side.
  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS,
    output HREADYS, grant_m, readyout_m, resp_m,
    input  HREADYOUTS, HRESPS, req_port, sel_m, addr_m, trans_m, write_m,
    input  size_m, burst_m, prot_m, lock_m, data_active, pend_cycles
  );

  // The input stage itself.
  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS,
    input  HREADYS, grant_m, readyout_m, resp_m,
    output HREADYOUTS, HRESPS, req_port, sel_m, addr_m, trans_m, write_m,
    output size_m, burst_m, prot_m, lock_m, data_active, pend_cycles
  );
endinterface

// File: rtl/l2_ahb_in_hold.sv
// Capture/replay register bank for a stalled address phase, with the live/held output mux.
module l2_ahb_in_hold
  import l2_ahb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_srst,
  input  logic              i_en,
  input  logic              i_sel,
  input  logic              i_hsel,
  input  logic [ADDR_W-1:0] i_addr,
  input  ahb_ctrl_t         i_ctrl,
  output logic              o_sel,
  output logic [ADDR_W-1:0] o_addr,
  output ahb_ctrl_t         o_ctrl
);

  logic [ADDR_W-1:0] r_addr;
  ahb_ctrl_t         r_ctrl;

  // All-zero control means trans=IDLE, so a reset bank never looks like a request.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_addr <= '0;
      r_ctrl <= '0;
    end else if (i_en) begin
      r_addr <= i_addr;
      r_ctrl <= i_ctrl;
    end
  end

  assign o_sel  = i_sel ? 1'b1   : i_hsel;
  assign o_addr = i_sel ? r_addr : i_addr;
  assign o_ctrl = i_sel ? r_ctrl : i_ctrl;

endmodule

// File: rtl/l2_ahb_in_stg.sv
// Per-master input stage: holds an ungranted address phase, stalls the master, replays on grant.
module l2_ahb_in_stg
  import l2_ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WCNT_W = 8
) (
  input logic           HCLK,
  input logic           HRESET,
  l2_ahb_in_stg_if.slave bus
);

  in_state_e         r_state;
  in_state_e         w_state_next;
  logic [WCNT_W-1:0] r_pend_cnt;
  logic [WCNT_W-1:0] w_pend_cnt_next;
  logic              w_new_tran;
  logic              w_capture;
  logic              w_pend;
  ahb_ctrl_t         w_ctrl_live;
  ahb_ctrl_t         w_ctrl_m;

  assign w_new_tran  = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;
  assign w_pend      = (r_state == ST_PEND);
  assign w_ctrl_live = {bus.HTRANSS, bus.HWRITES, bus.HSIZES, bus.HBURSTS,
                        bus.HPROTS, bus.HMASTLOCKS};

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state    <= ST_IDLE;
      r_pend_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pend_cnt <= w_pend_cnt_next;
    end
  end

  // A new_tran seen while pending is impossible on a compliant bus and is ignored.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_new_tran) begin
          if (bus.grant_m) begin
            w_state_next = ST_DATA;
          end else begin
            w_state_next = ST_PEND;
            w_capture    = 1'b1;
          end
        end
      end
      ST_PEND: begin
        if (bus.grant_m) w_state_next = ST_DATA;
      end
      ST_DATA: begin
        if (bus.readyout_m) begin
          if (!w_new_tran) begin
            w_state_next = ST_IDLE;
          end else if (!bus.grant_m) begin
            w_state_next = ST_PEND;
            w_capture    = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pend_cnt_next = r_pend_cnt;
    if (w_capture) begin
      w_pend_cnt_next = '0;
    end else if (w_pend && (r_pend_cnt != {WCNT_W{1'b1}})) begin
      w_pend_cnt_next = r_pend_cnt + 1'b1;
    end
  end

  l2_ahb_in_hold #(
    .ADDR_W (ADDR_W)
  ) u_hold (
    .i_clk  (HCLK),
    .i_srst (HRESET),
    .i_en   (w_capture),
    .i_sel  (w_pend),
    .i_hsel (bus.HSELS),
    .i_addr (bus.HADDRS),
    .i_ctrl (w_ctrl_live),
    .o_sel  (bus.sel_m),
    .o_addr (bus.addr_m),
    .o_ctrl (w_ctrl_m)
  );

  assign bus.trans_m     = w_ctrl_m.trans;
  assign bus.write_m     = w_ctrl_m.write;
  assign bus.size_m      = w_ctrl_m.size;
  assign bus.burst_m     = w_ctrl_m.burst;
  assign bus.prot_m      = w_ctrl_m.prot;
  assign bus.lock_m      = w_ctrl_m.lock;

  assign bus.req_port    = w_pend | w_new_tran;
  assign bus.data_active = (r_state == ST_DATA);
  assign bus.HREADYOUTS  = (r_state == ST_PEND) ? 1'b0 :
                           (r_state == ST_DATA) ? bus.readyout_m : 1'b1;
  assign bus.HRESPS      = (r_state == ST_DATA) ? bus.resp_m : RSP_OKAY;
  assign bus.pend_cycles = r_pend_cnt;

endmodule
